// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller (master) reads op/funct/zero and drives every datapath control.
interface mc_controller_if #(
   parameter int ALUCTRL_W = 5,
   parameter int CNT_W     = 32
);
   logic [5:0]           op;
   logic [5:0]           funct;
   logic                 zero;
   logic                 iord;
   logic                 memwrite;
   logic                 irwrite;
   logic                 regdst;
   logic                 memtoreg;
   logic                 regwrite;
   logic                 alusrca;
   logic [1:0]           alusrcb;
   logic [1:0]           pcsrc;
   logic                 pcen;
   logic [ALUCTRL_W-1:0] alucontrol;
   logic                 illegal;
   logic [CNT_W-1:0]     instret;
   logic [3:0]           state;

   modport master (
      input  op, funct, zero,
      output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, pcen, alucontrol, illegal, instret, state
   );

   modport slave (
      output op, funct, zero,
      input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, pcen, alucontrol, illegal, instret, state
   );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction over
// 3-5 cycles, with optional bne decode and a retired-instruction counter.
module mc_controller #(
   parameter int ALUCTRL_W = 5,
   parameter bit EN_BNE    = 1'b1,
   parameter int CNT_W     = 32
) (
   input  logic            clk,
   input  logic            reset,
   mc_controller_if.master bus
);
   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_e;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(5'b00010);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(5'b00110);
   localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(5'b00000);
   localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(5'b00001);
   localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(5'b00111);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   instret_q, instret_d;
   logic               is_lw, is_sw, is_r, is_beq, is_bne, is_addi, is_j, op_ok;
   logic               funct_ok;
   logic [ALUCTRL_W-1:0] funct_alu;
   logic               retire;

   always_comb begin
      is_lw   = (bus.op == OP_LW);
      is_sw   = (bus.op == OP_SW);
      is_r    = (bus.op == OP_R);
      is_beq  = (bus.op == OP_BEQ);
      is_bne  = (bus.op == OP_BNE) && EN_BNE;
      is_addi = (bus.op == OP_ADDI);
      is_j    = (bus.op == OP_J);
      op_ok   = is_lw | is_sw | is_r | is_beq | is_bne | is_addi | is_j;
   end

   // Unknown funct falls back to add so the ALU sees a benign operation.
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (bus.funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_d = S_FETCH;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:   state_d = S_DECODE;
         S_DECODE: begin
            if (is_lw | is_sw)        state_d = S_MEMADR;
            else if (is_r)            state_d = S_EXECUTE;
            else if (is_beq | is_bne) state_d = S_BRANCH;
            else if (is_addi)         state_d = S_ADDIEX;
            else if (is_j)            state_d = S_JUMP;
            else                      state_d = S_FETCH;
         end
         S_MEMADR:  state_d = is_lw ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = S_MEMWB;
         S_EXECUTE: state_d = funct_ok ? S_ALUWB : S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default:   state_d = S_FETCH;
      endcase
      instret_d = retire ? instret_q + 1'b1 : instret_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   // Reset gates every control low so nothing is written while it is held.
   always_comb begin
      bus.iord       = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.regwrite   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.pcsrc      = 2'b00;
      bus.pcen       = 1'b0;
      bus.alucontrol = ALU_AND;
      bus.illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.irwrite    = 1'b1;
            bus.alusrcb    = 2'b01;
            bus.alucontrol = ALU_ADD;
            bus.pcen       = 1'b1;
         end
         S_DECODE: begin
            bus.alusrcb    = 2'b11;
            bus.alucontrol = ALU_ADD;
            bus.illegal    = ~op_ok;
         end
         S_MEMADR, S_ADDIEX: begin
            bus.alusrca    = 1'b1;
            bus.alusrcb    = 2'b10;
            bus.alucontrol = ALU_ADD;
         end
         S_MEMRD:  bus.iord = 1'b1;
         S_MEMWB: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 1'b1;
         end
         S_MEMWR: begin
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
         end
         S_EXECUTE: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = funct_alu;
            bus.illegal    = ~funct_ok;
         end
         S_ALUWB: begin
            bus.regdst   = 1'b1;
            bus.regwrite = 1'b1;
         end
         S_BRANCH: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = ALU_SUB;
            bus.pcsrc      = 2'b01;
            bus.pcen       = (is_beq & bus.zero) | (is_bne & ~bus.zero);
         end
         S_ADDIWB: bus.regwrite = 1'b1;
         S_JUMP: begin
            bus.pcsrc = 2'b10;
            bus.pcen  = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         bus.iord       = 1'b0;
         bus.memwrite   = 1'b0;
         bus.irwrite    = 1'b0;
         bus.regdst     = 1'b0;
         bus.memtoreg   = 1'b0;
         bus.regwrite   = 1'b0;
         bus.alusrca    = 1'b0;
         bus.alusrcb    = 2'b00;
         bus.pcsrc      = 2'b00;
         bus.pcen       = 1'b0;
         bus.alucontrol = '0;
         bus.illegal    = 1'b0;
      end
   end

   assign bus.state   = state_q;
   assign bus.instret = instret_q;
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: a default build and a narrow build (EN_BNE=0,
// CNT_W=4, ALUCTRL_W=3) checked against a path/output model of the ISA.
module tb_mc_controller;
   localparam logic [5:0] OP_R = 6'd0, OP_LW = 6'd35, OP_SW = 6'd43, OP_BEQ = 6'd4;
   localparam logic [5:0] OP_BNE = 6'd5, OP_ADDI = 6'd8, OP_J = 6'd2;

   logic clk, rst1, rst2;
   int   total = 0;
   int   passed = 0;
   int   cnt1 = 0;
   int   cnt2 = 0;
   int   retired2 = 0;

   mc_controller_if #(.ALUCTRL_W(5), .CNT_W(32)) if1 ();
   mc_controller_if #(.ALUCTRL_W(3), .CNT_W(4))  if2 ();

   mc_controller #(.ALUCTRL_W(5), .EN_BNE(1'b1), .CNT_W(32)) dut1 (.clk(clk), .reset(rst1), .bus(if1));
   mc_controller #(.ALUCTRL_W(3), .EN_BNE(1'b0), .CNT_W(4))  dut2 (.clk(clk), .reset(rst2), .bus(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [17:0] obs1, obs2;
   assign obs1 = {if1.iord, if1.memwrite, if1.irwrite, if1.regdst, if1.memtoreg, if1.regwrite,
                  if1.alusrca, if1.alusrcb, if1.pcsrc, if1.pcen, if1.alucontrol, if1.illegal};
   assign obs2 = {if2.iord, if2.memwrite, if2.irwrite, if2.regdst, if2.memtoreg, if2.regwrite,
                  if2.alusrca, if2.alusrcb, if2.pcsrc, if2.pcen, 2'b00, if2.alucontrol, if2.illegal};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic bit op_ok(input logic [5:0] o, input bit en);
      return (o inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}) || (o == OP_BNE && en);
   endfunction

   function automatic bit funct_ok(input logic [5:0] f);
      return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
   endfunction

   function automatic logic [4:0] funct_alu(input logic [5:0] f);
      case (f)
         6'h22:   return 5'b00110;
         6'h24:   return 5'b00000;
         6'h25:   return 5'b00001;
         6'h2a:   return 5'b00111;
         default: return 5'b00010;
      endcase
   endfunction

   // Expected controls of one state, straight from the state output table.
   function automatic logic [17:0] exp_ctrl(input int s, input logic [5:0] o, input logic [5:0] f,
                                            input logic z, input bit en, input int aw);
      logic iord, mw, irw, rdst, m2r, rw, srca, pcen, ill;
      logic [1:0] srcb, pcs;
      logic [4:0] alu;
      {iord, mw, irw, rdst, m2r, rw, srca, pcen, ill} = '0;
      srcb = 2'b00; pcs = 2'b00; alu = 5'b00000;
      case (s)
         0:  begin irw = 1; srcb = 2'b01; alu = 5'b00010; pcen = 1; end
         1:  begin srcb = 2'b11; alu = 5'b00010; ill = !op_ok(o, en); end
         2, 9: begin srca = 1; srcb = 2'b10; alu = 5'b00010; end
         3:  iord = 1;
         4:  begin rw = 1; m2r = 1; end
         5:  begin iord = 1; mw = 1; end
         6:  begin srca = 1; alu = funct_alu(f); ill = !funct_ok(f); end
         7:  begin rdst = 1; rw = 1; end
         8:  begin
                srca = 1; alu = 5'b00110; pcs = 2'b01;
                pcen = (o == OP_BEQ) ? z : ((o == OP_BNE && en) ? !z : 1'b0);
             end
         10: rw = 1;
         11: begin pcs = 2'b10; pcen = 1; end
         default: ;
      endcase
      if (aw == 3) alu[4:3] = 2'b00;
      return {iord, mw, irw, rdst, m2r, rw, srca, srcb, pcs, pcen, alu, ill};
   endfunction

   task automatic check_cycle(input int sel, input int s, input logic [5:0] o,
                              input logic [5:0] f, input logic z);
      if (sel == 0) begin
         chk("state1", {28'd0, if1.state}, s);
         chk("ctrl1", {14'd0, obs1}, {14'd0, exp_ctrl(s, o, f, z, 1'b1, 5)});
         chk("instret1", if1.instret, cnt1);
      end else begin
         chk("state2", {28'd0, if2.state}, s);
         chk("ctrl2", {14'd0, obs2}, {14'd0, exp_ctrl(s, o, f, z, 1'b0, 3)});
         chk("instret2", {28'd0, if2.instret}, cnt2 % 16);
      end
   endtask

   task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic z);
      if1.op = o; if1.funct = f; if1.zero = z;
      if2.op = o; if2.funct = f; if2.zero = z;
   endtask

   // Runs one instruction from its FETCH cycle to the next FETCH cycle.
   task automatic run_instr(input int sel, input logic [5:0] o, input logic [5:0] f, input logic z);
      int seq[$];
      bit ret;
      bit en;
      en = (sel == 0);
      ret = 1'b1;
      case (o)
         OP_LW:   seq = '{0, 1, 2, 3, 4};
         OP_SW:   seq = '{0, 1, 2, 5};
         OP_R:    if (funct_ok(f)) seq = '{0, 1, 6, 7}; else begin seq = '{0, 1, 6}; ret = 0; end
         OP_BEQ:  seq = '{0, 1, 8};
         OP_BNE:  if (en) seq = '{0, 1, 8}; else begin seq = '{0, 1}; ret = 0; end
         OP_ADDI: seq = '{0, 1, 9, 10};
         OP_J:    seq = '{0, 1, 11};
         default: begin seq = '{0, 1}; ret = 0; end
      endcase
      drive(o, f, z);
      #1;
      foreach (seq[i]) begin
         check_cycle(sel, seq[i], o, f, z);
         @(negedge clk);
      end
      if (ret) begin
         if (sel == 0) cnt1++;
         else begin cnt2++; retired2++; end
      end
   endtask

   task automatic check_reset_outputs(input int sel);
      if (sel == 0) begin
         chk("rst_state1", {28'd0, if1.state}, 0);
         chk("rst_ctrl1", {14'd0, obs1}, 0);
         chk("rst_instret1", if1.instret, 0);
      end else begin
         chk("rst_state2", {28'd0, if2.state}, 0);
         chk("rst_ctrl2", {14'd0, obs2}, 0);
         chk("rst_instret2", {28'd0, if2.instret}, 0);
      end
   endtask

   function automatic logic [5:0] rand_op(input bit legal_only);
      logic [5:0] tbl[7];
      int k;
      tbl = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
      if (legal_only) begin
         k = $urandom_range(0, 5);
         return (k == 4) ? OP_J : tbl[k];
      end
      k = $urandom_range(0, 7);
      return (k == 7) ? 6'($urandom) : tbl[k];
   endfunction

   function automatic logic [5:0] rand_funct(input bit legal_only);
      logic [5:0] tbl[5];
      int k;
      tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      k = $urandom_range(0, legal_only ? 4 : 5);
      return (k == 5) ? 6'($urandom) : tbl[k];
   endfunction

   initial begin
      rst1 = 1'b1; rst2 = 1'b1;
      drive(OP_R, 6'h20, 1'b0);
      repeat (2) @(negedge clk);
      check_reset_outputs(0);
      check_reset_outputs(1);
      rst1 = 1'b0;
      #1;

      run_instr(0, OP_LW, 6'h00, 1'b0);
      run_instr(0, OP_SW, 6'h00, 1'b1);
      run_instr(0, OP_R, 6'h22, 1'b0);
      run_instr(0, OP_R, 6'h20, 1'b0);
      run_instr(0, OP_R, 6'h24, 1'b1);
      run_instr(0, OP_R, 6'h25, 1'b0);
      run_instr(0, OP_R, 6'h2a, 1'b0);
      run_instr(0, OP_R, 6'h3f, 1'b0);
      run_instr(0, OP_BEQ, 6'h00, 1'b1);
      run_instr(0, OP_BEQ, 6'h00, 1'b0);
      run_instr(0, OP_BNE, 6'h00, 1'b1);
      run_instr(0, OP_BNE, 6'h00, 1'b0);
      run_instr(0, OP_J, 6'h00, 1'b0);
      run_instr(0, OP_ADDI, 6'h00, 1'b0);
      run_instr(0, 6'h3f, 6'h00, 1'b0);

      // Reset in MEMRD of a lw: abandoned, uncounted, counter cleared.
      drive(OP_LW, 6'h00, 1'b0);
      #1;
      for (int i = 0; i < 3; i++) begin
         check_cycle(0, i, OP_LW, 6'h00, 1'b0);
         @(negedge clk);
      end
      check_cycle(0, 3, OP_LW, 6'h00, 1'b0);
      rst1 = 1'b1;
      #1;
      check_reset_outputs(0);
      @(negedge clk);
      check_reset_outputs(0);
      cnt1 = 0;
      rst1 = 1'b0;
      #1;

      for (int n = 0; n < 40; n++)
         run_instr(0, rand_op(1'b0), rand_funct(1'b0), 1'($urandom));

      rst1 = 1'b1;
      rst2 = 1'b0;
      #1;
      run_instr(1, OP_BNE, 6'h00, 1'b0);
      run_instr(1, OP_R, 6'h20, 1'b0);
      while (retired2 < 17)
         run_instr(1, rand_op(1'b1), rand_funct(1'b1), 1'($urandom));
      chk("wrap_instret2", {28'd0, if2.instret}, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
